// File: rtl/uart_cmd_rcv.sv
// 8N1 serial receiver that delivers one command byte behind a level ready flag.
// The ready flag holds until the consumer acknowledges it; framing errors and overruns are reported as one-cycle pulses.
module uart_cmd_rcv #(
  parameter int BAUD_DIV = 2604,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_cmd_rdy,
  output logic [7:0] cmd,
  output logic       cmd_rdy,
  output logic       frm_err,
  output logic       overrun
);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       STOP_IDX = 4'd9;

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_meta_d;
  logic             rx_s_q, rx_s_d;
  logic             rx_hist_q, rx_hist_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       cmd_q, cmd_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic             frm_err_q, frm_err_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    rx_meta_d = RX;
    rx_s_d    = rx_meta_q;
    rx_hist_d = rx_s_q;

    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    cmd_d     = cmd_q;
    frm_err_d = 1'b0;
    overrun_d = 1'b0;
    // A set later in this block overrides the clear.
    cmd_rdy_d = clr_cmd_rdy ? 1'b0 : cmd_rdy_q;

    case (state_q)
      IDLE: begin
        if (!rx_s_q && rx_hist_q) begin
          cnt_d   = HALF_BIT;
          bit_d   = 4'd0;
          shift_d = 8'h00;
          state_d = RECV;
        end
      end
      RECV: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d = FULL_BIT;
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd0) begin
            // Line back high at mid start bit: treat as a glitch.
            if (rx_s_q) begin
              state_d = IDLE;
              bit_d   = 4'd0;
            end
          end else if (bit_q < STOP_IDX) begin
            shift_d = {rx_s_q, shift_q[7:1]};
          end else begin
            state_d = IDLE;
            bit_d   = 4'd0;
            if (rx_s_q) begin
              cmd_d     = shift_q;
              cmd_rdy_d = 1'b1;
              overrun_d = cmd_rdy_q && !clr_cmd_rdy;
            end else begin
              frm_err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_hist_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= 4'd0;
      shift_q   <= 8'h00;
      cmd_q     <= 8'h00;
      cmd_rdy_q <= 1'b0;
      frm_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      rx_hist_q <= rx_hist_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
      frm_err_q <= frm_err_d;
      overrun_q <= overrun_d;
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign frm_err = frm_err_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Directed bench for uart_cmd_rcv at BAUD_DIV=16: frame timing, clear, overrun,
// framing error, start glitch and reset in the middle of a frame.
module tb_uart_cmd_rcv;

  localparam int BAUD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       clr;
  logic [7:0] cmd;
  logic       cmd_rdy;
  logic       frm_err;
  logic       overrun;

  int n_checks    = 0;
  int n_fail      = 0;
  int frm_err_cnt = 0;
  int overrun_cnt = 0;

  always #5 clk = ~clk;

  uart_cmd_rcv #(.BAUD_DIV(BAUD), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .RX          (rx),
    .clr_cmd_rdy (clr),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .frm_err     (frm_err),
    .overrun     (overrun)
  );

  always @(negedge clk) begin
    if (frm_err === 1'b1) frm_err_cnt++;
    if (overrun === 1'b1) overrun_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BAUD) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; clr = 1'b0;
    idle_cycles(3);
    n_checks++; if (cmd !== 8'h00) begin n_fail++; $display("FAIL reset_cmd: got %h expected 00", cmd); end
    n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b expected 0", cmd_rdy); end
    n_checks++; if (frm_err !== 1'b0) begin n_fail++; $display("FAIL reset_frm_err: got %b expected 0", frm_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    rst = 1'b0;
    idle_cycles(5);
  endtask

  task automatic test_frame_timing();
    int fe0;
    fe0 = frm_err_cnt;
    fork
      send_frame(8'h5A, 1'b1);
      begin
        // rx falls before edge 1; rx_s shows it after edge 2 (T0), so cmd_rdy rises after edge 156.
        repeat (155) @(posedge clk);
        @(negedge clk);
        n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL timing_early: cmd_rdy=%b expected 0 at T0+153", cmd_rdy); end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL timing_rise: cmd_rdy=%b expected 1 at T0+154", cmd_rdy); end
        n_checks++; if (cmd !== 8'h5A) begin n_fail++; $display("FAIL frame_5a: cmd=%h expected 5a", cmd); end
      end
    join
    idle_cycles(4);
    n_checks++; if (frm_err_cnt !== fe0) begin n_fail++; $display("FAIL frame_5a_frm_err: pulses=%0d expected %0d", frm_err_cnt, fe0); end
  endtask

  task automatic test_clear();
    pulse_clr();
    n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL clear_rdy: got %b expected 0", cmd_rdy); end
    n_checks++; if (cmd !== 8'h5A) begin n_fail++; $display("FAIL clear_cmd: got %h expected 5a", cmd); end
    idle_cycles(2);
    pulse_clr();
    idle_cycles(1);
    n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL clear2_rdy: got %b expected 0", cmd_rdy); end
    n_checks++; if (cmd !== 8'h5A) begin n_fail++; $display("FAIL clear2_cmd: got %h expected 5a", cmd); end
  endtask

  task automatic test_overrun();
    int ov0;
    ov0 = overrun_cnt;
    send_frame(8'h41, 1'b1);
    idle_cycles(4);
    n_checks++; if (cmd !== 8'h41) begin n_fail++; $display("FAIL ovr_first_cmd: got %h expected 41", cmd); end
    n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL ovr_first_rdy: got %b expected 1", cmd_rdy); end
    n_checks++; if (overrun_cnt !== ov0) begin n_fail++; $display("FAIL ovr_first_pulse: pulses=%0d expected %0d", overrun_cnt, ov0); end
    send_frame(8'hC3, 1'b1);
    idle_cycles(4);
    n_checks++; if (overrun_cnt !== ov0 + 1) begin n_fail++; $display("FAIL ovr_pulse: pulses=%0d expected %0d", overrun_cnt, ov0 + 1); end
    n_checks++; if (cmd !== 8'hC3) begin n_fail++; $display("FAIL ovr_cmd: got %h expected c3", cmd); end
    n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL ovr_rdy: got %b expected 1", cmd_rdy); end
    pulse_clr();
    idle_cycles(2);
  endtask

  task automatic test_frame_error();
    int fe0;
    int ov0;
    fe0 = frm_err_cnt;
    ov0 = overrun_cnt;
    send_frame(8'hFF, 1'b0);
    // Line stays low long enough that a level-triggered restart would finish a frame.
    idle_cycles(170);
    n_checks++; if (frm_err_cnt !== fe0 + 1) begin n_fail++; $display("FAIL ferr_pulse: pulses=%0d expected %0d", frm_err_cnt, fe0 + 1); end
    n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL ferr_rdy: got %b expected 0", cmd_rdy); end
    n_checks++; if (cmd !== 8'hC3) begin n_fail++; $display("FAIL ferr_cmd: got %h expected c3", cmd); end
    rx = 1'b1;
    idle_cycles(40);
    n_checks++; if (frm_err_cnt !== fe0 + 1) begin n_fail++; $display("FAIL ferr_after_high: pulses=%0d expected %0d", frm_err_cnt, fe0 + 1); end
    n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL ferr_after_rdy: got %b expected 0", cmd_rdy); end
    n_checks++; if (overrun_cnt !== ov0) begin n_fail++; $display("FAIL ferr_overrun: pulses=%0d expected %0d", overrun_cnt, ov0); end
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = frm_err_cnt;
    rx = 1'b0;
    idle_cycles(3);
    rx = 1'b1;
    idle_cycles(40);
    n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL glitch_rdy: got %b expected 0", cmd_rdy); end
    n_checks++; if (frm_err_cnt !== fe0) begin n_fail++; $display("FAIL glitch_frm_err: pulses=%0d expected %0d", frm_err_cnt, fe0); end
    send_frame(8'h00, 1'b1);
    idle_cycles(4);
    n_checks++; if (cmd !== 8'h00) begin n_fail++; $display("FAIL glitch_next_cmd: got %h expected 00", cmd); end
    n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL glitch_next_rdy: got %b expected 1", cmd_rdy); end
    n_checks++; if (frm_err_cnt !== fe0) begin n_fail++; $display("FAIL glitch_next_frm_err: pulses=%0d expected %0d", frm_err_cnt, fe0); end
  endtask

  task automatic test_reset_midframe();
    int ov0;
    int fe0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx = 1'b1;
    idle_cycles(8);
    rst = 1'b1;
    idle_cycles(3);
    n_checks++; if (cmd !== 8'h00) begin n_fail++; $display("FAIL midrst_cmd: got %h expected 00", cmd); end
    n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL midrst_rdy: got %b expected 0", cmd_rdy); end
    n_checks++; if (frm_err !== 1'b0) begin n_fail++; $display("FAIL midrst_frm_err: got %b expected 0", frm_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL midrst_overrun: got %b expected 0", overrun); end
    rst = 1'b0;
    idle_cycles(40);
    n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL postrst_idle_rdy: got %b expected 0", cmd_rdy); end
    ov0 = overrun_cnt;
    fe0 = frm_err_cnt;
    send_frame(8'h81, 1'b1);
    idle_cycles(4);
    n_checks++; if (cmd !== 8'h81) begin n_fail++; $display("FAIL postrst_cmd: got %h expected 81", cmd); end
    n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL postrst_rdy: got %b expected 1", cmd_rdy); end
    n_checks++; if (overrun_cnt !== ov0) begin n_fail++; $display("FAIL postrst_overrun: pulses=%0d expected %0d", overrun_cnt, ov0); end
    n_checks++; if (frm_err_cnt !== fe0) begin n_fail++; $display("FAIL postrst_frm_err: pulses=%0d expected %0d", frm_err_cnt, fe0); end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_clear();
    test_overrun();
    test_frame_error();
    test_glitch();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
